plnc_exec_unit: RTL and testbench

Single-cycle decode/execute unit for the 16-bit plnc CPU. It sits between the register file and the memory/write-back stages. It combinationally decodes one 16-bit instruction into register read addresses, consumes the read data, and evaluates the ALU operation and jump condition. It registers the complete execute result, with all control bits, for the downstream stages.

---
 rtl/plnc_pkg.sv | 81 ++++++++
 rtl/plnc_decoder.sv | 48 ++++
 rtl/plnc_exec_unit.sv | 108 ++++++++++
 tb/tb_plnc_exec_unit.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plnc_pkg.sv
// Shared encodings, field positions and decode/result records for the plnc execute stage.
// Imported by the decoder and the execute unit.
package plnc_pkg;

    localparam logic [1:0] CLS_MEM  = 2'b00;
    localparam logic [1:0] CLS_ALUR = 2'b01;
    localparam logic [1:0] CLS_JUMP = 2'b10;
    localparam logic [1:0] CLS_ALUI = 2'b11;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_NOT  = 5'b00101;
    localparam logic [4:0] ALU_SHL  = 5'b00110;
    localparam logic [4:0] ALU_SHR  = 5'b00111;
    localparam logic [4:0] ALU_SRA  = 5'b01000;
    localparam logic [4:0] ALU_SLT  = 5'b01001;
    localparam logic [4:0] ALU_SLTU = 5'b01010;
    localparam logic [4:0] ALU_PASS = 5'b01011;

    localparam logic [2:0] JMP_NEVER = 3'b000;
    localparam logic [2:0] JMP_ALWAYS = 3'b001;
    localparam logic [2:0] JMP_EQZ   = 3'b010;
    localparam logic [2:0] JMP_NEZ   = 3'b011;
    localparam logic [2:0] JMP_LTZ   = 3'b100;
    localparam logic [2:0] JMP_GEZ   = 3'b101;
    localparam logic [2:0] JMP_GTZ   = 3'b110;
    localparam logic [2:0] JMP_LEZ   = 3'b111;

    // Low bit of each instruction field.
    localparam int CLS_LO        = 14;
    localparam int MEM_STORE_BIT = 13;
    localparam int MEM_REG_LO    = 10;
    localparam int MEM_BASE_LO   = 7;
    localparam int R_CTRL_LO     = 9;
    localparam int R_RD_LO       = 6;
    localparam int R_RS1_LO      = 3;
    localparam int R_RS2_LO      = 0;
    localparam int J_CTRL_LO     = 11;
    localparam int J_TEST_LO     = 8;
    localparam int J_TGT_LO      = 5;
    localparam int I_RD_LO       = 11;
    localparam int I_RS1_LO      = 8;

    typedef struct packed {
        logic [2:0]  rs1_addr;
        logic [2:0]  rs2_addr;
        logic [2:0]  rd;
        logic [4:0]  alu_ctrl;
        logic [2:0]  jump_ctrl;
        logic [15:0] imm;
        logic        use_rs2;
        logic        is_jump;
        logic        reg_write;
        logic        wb_sel_mem;
        logic        mem_write;
    } dec_t;

    typedef struct packed {
        logic        valid;
        logic [15:0] result;
        logic [15:0] store_data;
        logic [2:0]  rd;
        logic        reg_write;
        logic        wb_sel_mem;
        logic        mem_write;
        logic        pc_write;
        logic [15:0] jump_target;
    } exec_out_t;

    function automatic logic [15:0] sext7(input logic [6:0] v);
        return {{9{v[6]}}, v};
    endfunction

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/plnc_decoder.sv
// Combinational instruction decode: register addresses, immediate and control bits.
// Fields a class does not use stay 0.
module plnc_decoder
    import plnc_pkg::*;
(
    input  logic [15:0] instr,
    output dec_t        dec
);

    always_comb begin
        dec = '0;
        case (instr[CLS_LO +: 2])
            CLS_MEM: begin
                dec.rs1_addr = instr[MEM_BASE_LO +: 3];
                dec.imm      = sext7(instr[6:0]);
                if (instr[MEM_STORE_BIT]) begin
                    dec.rs2_addr  = instr[MEM_REG_LO +: 3];
                    dec.mem_write = 1'b1;
                end else begin
                    dec.rd         = instr[MEM_REG_LO +: 3];
                    dec.reg_write  = 1'b1;
                    dec.wb_sel_mem = 1'b1;
                end
            end
            CLS_ALUR: begin
                dec.alu_ctrl  = instr[R_CTRL_LO +: 5];
                dec.rd        = instr[R_RD_LO +: 3];
                dec.rs1_addr  = instr[R_RS1_LO +: 3];
                dec.rs2_addr  = instr[R_RS2_LO +: 3];
                dec.use_rs2   = 1'b1;
                dec.reg_write = 1'b1;
            end
            CLS_JUMP: begin
                dec.jump_ctrl = instr[J_CTRL_LO +: 3];
                dec.rs1_addr  = instr[J_TEST_LO +: 3];
                dec.rs2_addr  = instr[J_TGT_LO +: 3];
                dec.is_jump   = 1'b1;
            end
            default: begin
                dec.rd        = instr[I_RD_LO +: 3];
                dec.rs1_addr  = instr[I_RS1_LO +: 3];
                dec.imm       = sext8(instr[7:0]);
                dec.reg_write = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/plnc_exec_unit.sv
// plnc decode/execute stage: ALU, jump condition and a single result register.
// Enables drop when no instruction arrives; data fields hold their last value.
module plnc_exec_unit
    import plnc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] instr,
    output logic [2:0]  rs1_addr,
    output logic [2:0]  rs2_addr,
    input  logic [15:0] rs1_val,
    input  logic [15:0] rs2_val,
    output logic        out_valid,
    output logic [15:0] out_result,
    output logic [15:0] out_store_data,
    output logic [2:0]  out_rd,
    output logic        out_reg_write,
    output logic        out_wb_sel_mem,
    output logic        out_mem_write,
    output logic        out_pc_write,
    output logic [15:0] out_jump_target
);

    dec_t        dec;
    logic [15:0] op_b;
    logic [15:0] alu_res;
    logic        cond;
    exec_out_t   res_d, res_q;

    plnc_decoder u_dec (
        .instr (instr),
        .dec   (dec)
    );

    assign rs1_addr = dec.rs1_addr;
    assign rs2_addr = dec.rs2_addr;
    assign op_b     = dec.use_rs2 ? rs2_val : dec.imm;

    always_comb begin
        alu_res = '0;
        case (dec.alu_ctrl)
            ALU_ADD:  alu_res = rs1_val + op_b;
            ALU_SUB:  alu_res = rs1_val - op_b;
            ALU_AND:  alu_res = rs1_val & op_b;
            ALU_OR:   alu_res = rs1_val | op_b;
            ALU_XOR:  alu_res = rs1_val ^ op_b;
            ALU_NOT:  alu_res = ~rs1_val;
            ALU_SHL:  alu_res = rs1_val << op_b[3:0];
            ALU_SHR:  alu_res = rs1_val >> op_b[3:0];
            ALU_SRA:  alu_res = $unsigned($signed(rs1_val) >>> op_b[3:0]);
            ALU_SLT:  alu_res = {15'd0, $signed(rs1_val) < $signed(op_b)};
            ALU_SLTU: alu_res = {15'd0, rs1_val < op_b};
            ALU_PASS: alu_res = op_b;
            default:  alu_res = '0;
        endcase
    end

    // Test register is compared as a signed value against zero.
    always_comb begin
        cond = 1'b0;
        case (dec.jump_ctrl)
            JMP_NEVER:  cond = 1'b0;
            JMP_ALWAYS: cond = 1'b1;
            JMP_EQZ:    cond = (rs1_val == '0);
            JMP_NEZ:    cond = (rs1_val != '0);
            JMP_LTZ:    cond = rs1_val[15];
            JMP_GEZ:    cond = ~rs1_val[15];
            JMP_GTZ:    cond = ~rs1_val[15] && (rs1_val != '0);
            default:    cond = rs1_val[15] || (rs1_val == '0);
        endcase
    end

    always_comb begin
        res_d           = res_q;
        res_d.valid     = 1'b0;
        res_d.reg_write = 1'b0;
        res_d.mem_write = 1'b0;
        res_d.pc_write  = 1'b0;
        if (in_valid) begin
            res_d.valid       = 1'b1;
            res_d.result      = alu_res;
            res_d.store_data  = rs2_val;
            res_d.rd          = dec.rd;
            res_d.reg_write   = dec.reg_write;
            res_d.wb_sel_mem  = dec.wb_sel_mem;
            res_d.mem_write   = dec.mem_write;
            res_d.pc_write    = dec.is_jump && cond;
            res_d.jump_target = rs2_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) res_q <= '0;
        else      res_q <= res_d;
    end

    assign out_valid       = res_q.valid;
    assign out_result      = res_q.result;
    assign out_store_data  = res_q.store_data;
    assign out_rd          = res_q.rd;
    assign out_reg_write   = res_q.reg_write;
    assign out_wb_sel_mem  = res_q.wb_sel_mem;
    assign out_mem_write   = res_q.mem_write;
    assign out_pc_write    = res_q.pc_write;
    assign out_jump_target = res_q.jump_target;

endmodule

// File: tb/tb_plnc_exec_unit.sv
// Scoreboard bench for plnc_exec_unit: expectations queued at issue, checked one cycle later.
module tb_plnc_exec_unit;

    typedef struct packed {
        logic        valid;
        logic [15:0] result;
        logic [15:0] store_data;
        logic [2:0]  rd;
        logic        reg_write;
        logic        wb_sel_mem;
        logic        mem_write;
        logic        pc_write;
        logic [15:0] jump_target;
    } obs_t;

    typedef struct {
        string name;
        obs_t  e;
        obs_t  m;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] instr, rs1_val, rs2_val;
    logic [2:0]  rs1_addr, rs2_addr, out_rd;
    logic        out_valid, out_reg_write, out_wb_sel_mem, out_mem_write, out_pc_write;
    logic [15:0] out_result, out_store_data, out_jump_target;

    int  n_cmp = 0;
    int  n_bad = 0;
    sb_t sbq[$];

    plnc_exec_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .out_valid(out_valid), .out_result(out_result), .out_store_data(out_store_data),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .out_wb_sel_mem(out_wb_sel_mem),
        .out_mem_write(out_mem_write), .out_pc_write(out_pc_write),
        .out_jump_target(out_jump_target)
    );

    always #5 clk = ~clk;

    function automatic obs_t observed();
        obs_t o;
        o.valid       = out_valid;
        o.result      = out_result;
        o.store_data  = out_store_data;
        o.rd          = out_rd;
        o.reg_write   = out_reg_write;
        o.wb_sel_mem  = out_wb_sel_mem;
        o.mem_write   = out_mem_write;
        o.pc_write    = out_pc_write;
        o.jump_target = out_jump_target;
        return o;
    endfunction

    function automatic obs_t mk(bit v, logic [15:0] res, logic [15:0] sd, logic [2:0] rd,
                                bit rw, bit wb, bit mw, bit pw, logic [15:0] jt);
        obs_t o;
        o = '{v, res, sd, rd, rw, wb, mw, pw, jt};
        return o;
    endfunction

    // Fields whose value the bench does not pin down are excluded from a comparison.
    function automatic obs_t msk(bit res_on, bit sd_on, bit rd_on);
        obs_t o;
        o = '1;
        if (!res_on) o.result = '0;
        if (!sd_on)  o.store_data = '0;
        if (!rd_on)  o.rd = '0;
        return o;
    endfunction

    function automatic logic [15:0] alu_ref(logic [4:0] c, logic [15:0] a, logic [15:0] b);
        logic [15:0] r;
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (c)
            5'd0:  r = a + b;
            5'd1:  r = a + (~b) + 16'd1;
            5'd2:  r = a & b;
            5'd3:  r = a | b;
            5'd4:  r = a ^ b;
            5'd5:  r = ~a;
            5'd6:  r = a << b[3:0];
            5'd7:  r = a >> b[3:0];
            5'd8:  begin
                r = a;
                for (int k = 0; k < int'(b[3:0]); k++) r = {r[15], r[15:1]};
            end
            5'd9:  r = (sa < sb) ? 16'd1 : 16'd0;
            5'd10: r = (int'(a) < int'(b)) ? 16'd1 : 16'd0;
            5'd11: r = b;
            default: r = 16'd0;
        endcase
        return r;
    endfunction

    function automatic bit jmp_ref(logic [2:0] jc, logic [15:0] v);
        int s;
        s = $signed(v);
        case (jc)
            3'd0: return 1'b0;
            3'd1: return 1'b1;
            3'd2: return s == 0;
            3'd3: return s != 0;
            3'd4: return s < 0;
            3'd5: return s >= 0;
            3'd6: return s > 0;
            default: return s <= 0;
        endcase
    endfunction

    task automatic drive(input logic [15:0] i, input logic [15:0] a, input logic [15:0] b);
        in_valid = 1'b1;
        instr    = i;
        rs1_val  = a;
        rs2_val  = b;
    endtask

    task automatic push(input string nm, input obs_t e, input obs_t m);
        sb_t s;
        s.name = nm;
        s.e    = e;
        s.m    = m;
        sbq.push_back(s);
    endtask

    task automatic test_reset();
        obs_t got;
        rst = 1'b0;
        in_valid = 1'b0;
        instr = '0; rs1_val = '0; rs2_val = '0;
        #12;
        got = observed();
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got %h expected 0", got);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        got = observed();
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL reset_idle_edge: got %h expected 0", got);
        end
    endtask

    task automatic test_alu_basic();
        obs_t got;
        sb_t  s;
        @(negedge clk);
        drive(16'h4053, 16'd5, 16'd7);
        #1;
        n_cmp++;
        if ({rs1_addr, rs2_addr} !== {3'd2, 3'd3}) begin
            n_bad++;
            $display("FAIL add_addr: got %0d/%0d expected 2/3", rs1_addr, rs2_addr);
        end
        push("add", mk(1, 16'd12, 16'd0, 3'd1, 1, 0, 0, 0, 16'd7), msk(1, 0, 1));
        @(negedge clk);
        got = observed(); s = sbq.pop_front();
        n_cmp++;
        if ((got & s.m) !== (s.e & s.m)) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h mask %h", s.name, got, s.e, s.m);
        end
        drive(16'h4253, 16'd3, 16'd5);
        push("sub_wrap", mk(1, 16'hFFFE, 16'd0, 3'd1, 1, 0, 0, 0, 16'd5), msk(1, 0, 1));
        @(negedge clk);
        got = observed(); s = sbq.pop_front();
        n_cmp++;
        if ((got & s.m) !== (s.e & s.m)) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h mask %h", s.name, got, s.e, s.m);
        end
    endtask

    task automatic test_jump();
        obs_t got;
        sb_t  s;
        drive(16'h9140, 16'd0, 16'h0020);
        #1;
        n_cmp++;
        if ({rs1_addr, rs2_addr} !== {3'd1, 3'd2}) begin
            n_bad++;
            $display("FAIL jmp_addr: got %0d/%0d expected 1/2", rs1_addr, rs2_addr);
        end
        push("jz_taken", mk(1, 0, 0, 3'd0, 0, 0, 0, 1, 16'h0020), msk(0, 0, 1));
        @(negedge clk);
        got = observed(); s = sbq.pop_front();
        n_cmp++;
        if ((got & s.m) !== (s.e & s.m)) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h mask %h", s.name, got, s.e, s.m);
        end
        drive(16'h9140, 16'd1, 16'h0020);
        push("jz_not_taken", mk(1, 0, 0, 3'd0, 0, 0, 0, 0, 16'h0020), msk(0, 0, 1));
        @(negedge clk);
        got = observed(); s = sbq.pop_front();
        n_cmp++;
        if ((got & s.m) !== (s.e & s.m)) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h mask %h", s.name, got, s.e, s.m);
        end
    endtask

    task automatic test_addi_mem_hold();
        obs_t got;
        sb_t  s;
        drive(16'hDCFF, 16'h0010, 16'h1234);
        #1;
        n_cmp++;
        if ({rs1_addr, rs2_addr} !== {3'd4, 3'd0}) begin
            n_bad++;
            $display("FAIL addi_addr: got %0d/%0d expected 4/0", rs1_addr, rs2_addr);
        end
        push("addi_neg", mk(1, 16'h000F, 0, 3'd3, 1, 0, 0, 0, 16'h1234), msk(1, 0, 1));
        @(negedge clk);
        drive(16'h0984, 16'h0100, 16'h0000);
        #1;
        n_cmp++;
        if (rs1_addr !== 3'd3) begin
            n_bad++;
            $display("FAIL load_addr: got %0d expected 3", rs1_addr);
        end
        got = observed(); s = sbq.pop_front();
        n_cmp++;
        if ((got & s.m) !== (s.e & s.m)) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h mask %h", s.name, got, s.e, s.m);
        end
        push("load", mk(1, 16'h0104, 0, 3'd2, 1, 1, 0, 0, 16'h0000), msk(1, 0, 1));
        @(negedge clk);
        in_valid = 1'b0;
        instr = 16'h4053;
        push("hold_after_load", mk(0, 16'h0104, 0, 3'd2, 0, 1, 0, 0, 16'h0000), msk(1, 0, 1));
        for (int k = 0; k < 2; k++) begin
            got = observed(); s = sbq.pop_front();
            n_cmp++;
            if ((got & s.m) !== (s.e & s.m)) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h mask %h", s.name, got, s.e, s.m);
            end
            @(negedge clk);
        end
        drive(16'h2984, 16'h0100, 16'hBEEF);
        #1;
        n_cmp++;
        if ({rs1_addr, rs2_addr} !== {3'd3, 3'd2}) begin
            n_bad++;
            $display("FAIL store_addr: got %0d/%0d expected 3/2", rs1_addr, rs2_addr);
        end
        push("store", mk(1, 16'h0104, 16'hBEEF, 0, 0, 0, 1, 0, 16'hBEEF), msk(1, 1, 0));
        @(negedge clk);
        in_valid = 1'b0;
        push("hold_after_store", mk(0, 16'h0104, 16'hBEEF, 0, 0, 0, 0, 0, 16'hBEEF), msk(1, 1, 0));
        for (int k = 0; k < 2; k++) begin
            got = observed(); s = sbq.pop_front();
            n_cmp++;
            if ((got & s.m) !== (s.e & s.m)) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h mask %h", s.name, got, s.e, s.m);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back_alu();
        obs_t got;
        sb_t  s;
        logic [4:0]  c;
        logic [2:0]  rd, r1, r2;
        logic [15:0] a, b;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) begin
                got = observed(); s = sbq.pop_front();
                n_cmp++;
                if ((got & s.m) !== (s.e & s.m)) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h mask %h", s.name, got, s.e, s.m);
                end
            end
            if (k < 40) begin
                c  = (k < 32) ? 5'(k) : 5'($urandom_range(6, 10));
                rd = 3'($urandom); r1 = 3'($urandom); r2 = 3'($urandom);
                a  = (k % 3 == 0) ? 16'h8001 : 16'($urandom);
                b  = (k % 4 == 0) ? 16'hFFF0 | 16'(k % 16) : 16'($urandom);
                drive({2'b01, c, rd, r1, r2}, a, b);
                push($sformatf("alu_op%0d", c), mk(1, alu_ref(c, a, b), 0, rd, 1, 0, 0, 0, b),
                     msk(1, 0, 1));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back_jump();
        obs_t got;
        sb_t  s;
        logic [15:0] vals [5];
        logic [15:0] tgt;
        vals = '{16'h0000, 16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF};
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) begin
                got = observed(); s = sbq.pop_front();
                n_cmp++;
                if ((got & s.m) !== (s.e & s.m)) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h mask %h", s.name, got, s.e, s.m);
                end
            end
            if (k < 40) begin
                tgt = 16'($urandom);
                drive({2'b10, 3'(k / 5), 3'd5, 3'd6, 5'd0}, vals[k % 5], tgt);
                push($sformatf("jmp%0d_v%h", k / 5, vals[k % 5]),
                     mk(1, 0, 0, 0, 0, 0, 0, jmp_ref(3'(k / 5), vals[k % 5]), tgt), msk(0, 0, 1));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midstream();
        obs_t got;
        sb_t  s;
        drive(16'h4053, 16'd5, 16'd7);
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset_valid: got %b expected 1", out_valid);
        end
        #1 rst = 1'b0;
        #1;
        got = observed();
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got %h expected 0", got);
        end
        @(negedge clk);
        @(negedge clk);
        got = observed();
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL reset_held: got %h expected 0", got);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        got = observed();
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL post_reset_idle: got %h expected 0", got);
        end
        drive(16'h4253, 16'd3, 16'd5);
        push("post_reset_sub", mk(1, 16'hFFFE, 0, 3'd1, 1, 0, 0, 0, 16'd5), msk(1, 0, 1));
        @(negedge clk);
        in_valid = 1'b0;
        got = observed(); s = sbq.pop_front();
        n_cmp++;
        if ((got & s.m) !== (s.e & s.m)) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h mask %h", s.name, got, s.e, s.m);
        end
    endtask

    initial begin
        test_reset();
        test_alu_basic();
        test_jump();
        test_addi_mem_hold();
        test_back_to_back_alu();
        test_back_to_back_jump();
        test_reset_midstream();
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
